// File: rtl/hqm_aw_rrwrand_grant_ctl_if.sv
// Winner/grant handshake bundle between the rr/wrand arbiter, the grant
// control block and the grant consumer.
interface hqm_aw_rrwrand_grant_ctl_if #(
  parameter int NUM_PRIB2  = 3,
  parameter int NUM_REQSB2 = 3
);
  logic                  arb_winner_v;
  logic [NUM_PRIB2-1:0]  arb_winner_pri;
  logic [NUM_REQSB2-1:0] arb_winner;
  logic                  arb_winner_boosted;
  logic                  arb_accept;

  logic                  gnt_v;
  logic                  gnt_ready;
  logic [NUM_PRIB2-1:0]  gnt_pri;
  logic [NUM_REQSB2-1:0] gnt_req;
  logic                  gnt_boosted;

  // Arbiter and grant consumer side
  modport master (
    output arb_winner_v, arb_winner_pri, arb_winner, arb_winner_boosted, gnt_ready,
    input  arb_accept, gnt_v, gnt_pri, gnt_req, gnt_boosted
  );

  // Grant control side
  modport slave (
    input  arb_winner_v, arb_winner_pri, arb_winner, arb_winner_boosted, gnt_ready,
    output arb_accept, gnt_v, gnt_pri, gnt_req, gnt_boosted
  );
endinterface

// File: rtl/hqm_aw_rrwrand_grant_ctl.sv
// Captures the arbiter winner into a 2-entry grant skid buffer, owns the
// per-priority round-robin index and counts boosted grants.
module hqm_aw_rrwrand_grant_ctl #(
  parameter int NUM_REQS   = 8,
  parameter int NUM_PRI    = 8,
  parameter int NUM_REQSB2 = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int NUM_PRIB2  = (NUM_PRI > 1) ? $clog2(NUM_PRI) : 1,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  hqm_aw_rrwrand_grant_ctl_if.slave      bus,
  output logic [NUM_PRI*NUM_REQSB2-1:0]  index_f,
  output logic [CNT_W-1:0]               boost_cnt,
  input  logic                           boost_cnt_clr
);

  typedef struct packed {
    logic [NUM_PRIB2-1:0]  pri;
    logic [NUM_REQSB2-1:0] req;
    logic                  boosted;
  } gnt_ent_t;

  localparam logic [NUM_REQSB2-1:0] IDX_RST = NUM_REQSB2'(NUM_REQS - 1);

  logic [1:0]            occ_q, occ_d;
  gnt_ent_t              head_q, head_d;
  gnt_ent_t              tail_q, tail_d;
  gnt_ent_t              new_ent;
  logic                  push, pop, pri_ok;
  logic [NUM_REQSB2-1:0] index_q [NUM_PRI];
  logic [CNT_W-1:0]      boost_cnt_q;

  assign push    = bus.arb_accept;
  assign pop     = bus.gnt_v & bus.gnt_ready;
  assign new_ent = '{pri: bus.arb_winner_pri, req: bus.arb_winner, boosted: bus.arb_winner_boosted};
  // Extra MSB keeps the range check meaningful when NUM_PRI is a power of 2
  assign pri_ok  = ({1'b0, bus.arb_winner_pri} < (NUM_PRIB2 + 1)'(NUM_PRI));

  assign bus.arb_accept  = bus.arb_winner_v & (occ_q != 2'd2);
  assign bus.gnt_v       = (occ_q != 2'd0);
  assign bus.gnt_pri     = head_q.pri;
  assign bus.gnt_req     = head_q.req;
  assign bus.gnt_boosted = head_q.boosted;
  assign boost_cnt       = boost_cnt_q;

  always_comb begin
    // NOTE: defaults first so every path assigns every target; no latch is inferred.
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = new_ent;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_ent;
        end else if (push) begin
          tail_d = new_ent;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
    endcase
  end

  // NOTE: both entries are reset, not just occupancy, so gnt_* read 0 out of reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all state so every flop samples pre-edge values.
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PRI; p++) index_q[p] <= IDX_RST;
    end else if (push && pri_ok) begin
      index_q[bus.arb_winner_pri] <= bus.arb_winner;
    end
  end

  for (genvar p = 0; p < NUM_PRI; p++) begin : g_index
    assign index_f[p*NUM_REQSB2 +: NUM_REQSB2] = index_q[p];
  end

  // Clear wins over a same-cycle boosted accept
  always_ff @(posedge clk) begin
    if (rst || boost_cnt_clr) begin
      boost_cnt_q <= '0;
    end else if (push && bus.arb_winner_boosted && !(&boost_cnt_q)) begin
      boost_cnt_q <= boost_cnt_q + CNT_W'(1);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (occ_q != 2'd2));

  a_gnt_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.gnt_v && !bus.gnt_ready) |=>
      (bus.gnt_v && $stable({bus.gnt_pri, bus.gnt_req, bus.gnt_boosted})));

  a_req_range: assert property (@(posedge clk) disable iff (rst)
    bus.arb_winner_v |-> ({1'b0, bus.arb_winner} < (NUM_REQSB2 + 1)'(NUM_REQS)));

  a_pri_range: assert property (@(posedge clk) disable iff (rst)
    bus.arb_winner_v |-> pri_ok);

endmodule

// File: tb/tb_hqm_aw_rrwrand_grant_ctl.sv
// Scoreboard bench for the grant control block: expected grants are queued
// as winners are accepted and compared when they reach the gnt_* outputs.
module tb_hqm_aw_rrwrand_grant_ctl;
  localparam int NR = 8;
  localparam int NP = 8;
  localparam int RB = 3;
  localparam int PB = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  logic [NP*RB-1:0] index_f;
  logic [CW-1:0]    boost_cnt;
  logic             boost_cnt_clr;

  hqm_aw_rrwrand_grant_ctl_if #(.NUM_PRIB2(PB), .NUM_REQSB2(RB)) bus ();

  hqm_aw_rrwrand_grant_ctl #(
    .NUM_REQS(NR), .NUM_PRI(NP), .NUM_REQSB2(RB), .NUM_PRIB2(PB), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .index_f      (index_f),
    .boost_cnt    (boost_cnt),
    .boost_cnt_clr(boost_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [PB+RB:0] sb [$];
  logic [RB-1:0]  m_idx [NP];
  int             m_cnt;

  function automatic logic [NP*RB-1:0] exp_index();
    logic [NP*RB-1:0] v;
    for (int p = 0; p < NP; p++) v[p*RB +: RB] = m_idx[p];
    return v;
  endfunction

  // One clock of stimulus; inputs are driven just after a falling edge.
  task automatic drive_cycle(input logic v, input logic [PB-1:0] pri, input logic [RB-1:0] req,
                             input logic b, input logic rdy, input logic clr);
    logic exp_acc;
    bus.arb_winner_v       = v;
    bus.arb_winner_pri     = pri;
    bus.arb_winner         = req;
    bus.arb_winner_boosted = b;
    bus.gnt_ready          = rdy;
    boost_cnt_clr          = clr;
    #1;
    exp_acc = v && (sb.size() < 2);
    n_total++;
    if (bus.arb_accept !== exp_acc)
      $display("FAIL arb_accept t=%0t got=%b exp=%b", $time, bus.arb_accept, exp_acc);
    else n_pass++;
    n_total++;
    if (bus.gnt_v !== (sb.size() != 0))
      $display("FAIL gnt_v t=%0t got=%b exp=%b", $time, bus.gnt_v, sb.size() != 0);
    else n_pass++;
    if (sb.size() != 0) begin
      n_total++;
      if ({bus.gnt_pri, bus.gnt_req, bus.gnt_boosted} !== sb[0])
        $display("FAIL gnt_entry t=%0t got=%h exp=%h", $time,
                 {bus.gnt_pri, bus.gnt_req, bus.gnt_boosted}, sb[0]);
      else n_pass++;
      if (rdy) void'(sb.pop_front());
    end
    if (exp_acc) begin
      sb.push_back({pri, req, b});
      m_idx[pri] = req;
    end
    if (clr) m_cnt = 0;
    else if (exp_acc && b && m_cnt < CMAX) m_cnt++;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (index_f !== exp_index())
      $display("FAIL index_f t=%0t got=%h exp=%h", $time, index_f, exp_index());
    else n_pass++;
    n_total++;
    if (boost_cnt !== CW'(m_cnt))
      $display("FAIL boost_cnt t=%0t got=%0d exp=%0d", $time, boost_cnt, m_cnt);
    else n_pass++;
  endtask

  task automatic do_reset();
    bus.arb_winner_v       = 1'b0;
    bus.arb_winner_pri     = '0;
    bus.arb_winner         = '0;
    bus.arb_winner_boosted = 1'b0;
    bus.gnt_ready          = 1'b0;
    boost_cnt_clr          = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int p = 0; p < NP; p++) m_idx[p] = RB'(NR - 1);
    m_cnt = 0;
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    n_total++;
    if (bus.gnt_v !== 1'b0) $display("FAIL %s_gnt_v got=%b exp=0", tag, bus.gnt_v);
    else n_pass++;
    n_total++;
    if ({bus.gnt_pri, bus.gnt_req, bus.gnt_boosted} !== '0)
      $display("FAIL %s_gnt_fields got=%h exp=0", tag, {bus.gnt_pri, bus.gnt_req, bus.gnt_boosted});
    else n_pass++;
    n_total++;
    if (index_f !== {NP{3'd7}}) $display("FAIL %s_index got=%h exp=%h", tag, index_f, {NP{3'd7}});
    else n_pass++;
    n_total++;
    if (boost_cnt !== '0) $display("FAIL %s_boost_cnt got=%0d exp=0", tag, boost_cnt);
    else n_pass++;
    n_total++;
    if (bus.arb_accept !== 1'b0) $display("FAIL %s_arb_accept got=%b exp=0", tag, bus.arb_accept);
    else n_pass++;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && sb.size() != 0; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (sb.size() != 0) $display("FAIL drain_timeout left=%0d exp=0", sb.size());
    else n_pass++;
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_state("reset");
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 3'd3, 3'd5, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (index_f !== {3'd7, 3'd7, 3'd7, 3'd7, 3'd5, 3'd7, 3'd7, 3'd7})
      $display("FAIL single_index got=%h exp=%h", index_f, {3'd7, 3'd7, 3'd7, 3'd7, 3'd5, 3'd7, 3'd7, 3'd7});
    else n_pass++;
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd2, 3'd4, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (index_f[1*RB +: RB] !== 3'd1 || index_f[2*RB +: RB] !== 3'd7)
      $display("FAIL full_index got=%h/%h exp=1/7", index_f[1*RB +: RB], index_f[2*RB +: RB]);
    else n_pass++;
    drain();
  endtask

  task automatic test_ready_pulse();
    drive_cycle(1'b1, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd4, 3'd3, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd5, 3'd6, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (index_f[5*RB +: RB] !== 3'd6) $display("FAIL pulse_index got=%0d exp=6", index_f[5*RB +: RB]);
    else n_pass++;
    drain();
  endtask

  task automatic test_boost_saturate();
    for (int i = 0; i < 17; i++)
      drive_cycle(1'b1, PB'(i % NP), RB'((i * 3) % NR), 1'b1, 1'b1, 1'b0);
    n_total++;
    if (boost_cnt !== 4'd15) $display("FAIL boost_sat got=%0d exp=15", boost_cnt);
    else n_pass++;
    drive_cycle(1'b1, 3'd0, 3'd1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (boost_cnt !== 4'd0) $display("FAIL boost_clr got=%0d exp=0", boost_cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_midop();
    drive_cycle(1'b1, 3'd6, 3'd2, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_reset_state("midop");
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_ready_pulse();
    test_boost_saturate();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hqm_aw_rrwrand_grant_ctl.md
Name: hqm_AW_rrwrand_grant_ctl

Overview:
- Downstream companion to the two-stage round-robin / weighted-random arbiter with external round-robin index.
- Captures the arbiter's combinational winner into a 2-entry grant skid buffer with a valid/ready handshake.
- Owns and returns the per-priority round-robin index state, updated only on accepted winners.
- Keeps a saturating count of boosted grants for debug and telemetry.

Parameters:
- NUM_REQS, 8, requestors per priority.
- NUM_PRI, 8, priority levels.
- NUM_REQSB2, AW_logb2(NUM_REQS-1)+1, requestor index width.
- NUM_PRIB2, AW_logb2(NUM_PRI-1)+1, priority index width.
- CNT_W, 16, boosted-grant counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arb_winner_v  in  1  arbiter has a winner this cycle.
- arb_winner_pri  in  NUM_PRIB2  winning priority.
- arb_winner  in  NUM_REQSB2  winning requestor.
- arb_winner_boosted  in  1  winner was selected by a weight boost.
- arb_accept  out  1  winner captured this cycle; requestor may drop or decrement its request.
- index_f  out  NUM_PRI*NUM_REQSB2  per-priority last-granted requestor; slice p at [p*NUM_REQSB2 +: NUM_REQSB2].
- gnt_v  out  1  grant valid.
- gnt_ready  in  1  consumer accepts the grant.
- gnt_pri  out  NUM_PRIB2  granted priority.
- gnt_req  out  NUM_REQSB2  granted requestor.
- gnt_boosted  out  1  granted entry was boosted.
- boost_cnt  out  CNT_W  saturating count of accepted boosted winners.
- boost_cnt_clr  in  1  clears boost_cnt.

Behaviour:
- Reset (rst=1 at a clock edge):
  - every index_f slice = NUM_REQS-1, so the first search starts at requestor 0;
  - skid buffer empty; gnt_v=0; gnt_pri, gnt_req and gnt_boosted = 0;
  - boost_cnt=0.
  - Reset mid-operation discards all buffered grants with no handshake.
- arb_accept = arb_winner_v & (occupancy<2). Purely combinational, with no dependency on gnt_ready in the same cycle.
- Skid buffer:
  - 2-entry FIFO; the head drives the gnt_* outputs; gnt_v = (occupancy!=0).
  - Pop when gnt_v & gnt_ready. Push when arb_accept.
  - Simultaneous push and pop keeps occupancy unchanged and preserves ordering.
  - Full means occupancy==2: arb_accept=0 and index_f is not updated.
  - Pop on empty is impossible because gnt_v=0.
- Latency: an accepted winner appears on gnt_* the next cycle if the buffer was empty, or behind the older entry otherwise.
- Index update:
  - On arb_accept, index_f[arb_winner_pri] <= arb_winner on the next edge; all other slices hold.
  - Re-granting the same requestor twice leaves the slice value unchanged.
  - arb_winner_pri >= NUM_PRI when NUM_PRI is not a power of 2 must never be produced by the arbiter. If it is, no update occurs and an assertion fires.
- boost_cnt:
  - Increments on arb_accept & arb_winner_boosted and saturates at 2^CNT_W-1.
  - boost_cnt_clr has priority over increment: the same-cycle boosted accept is lost and the count becomes 0.
- Assertions:
  - no push when full;
  - gnt_* stable while gnt_v & ~gnt_ready;
  - arb_winner < NUM_REQS whenever arb_winner_v.

Test Plan:
- Reset then idle -> every index_f slice = 7 (NUM_REQS=8); gnt_v=0; boost_cnt=0; arb_accept=0.
- Single winner pri=3, req=5, gnt_ready=1 -> arb_accept=1 in that cycle; the next cycle gives gnt_v=1, gnt_pri=3, gnt_req=5; index_f slice 3 = 5 and other slices = 7.
- gnt_ready=0, three consecutive winners (p1/r0, p1/r1, p2/r4) -> accepts on cycles 1-2 only, arb_accept=0 on cycle 3; slice 1 = 1 and slice 2 remains 7. Raise gnt_ready -> grants p1/r0 then p1/r1 in order.
- Buffer full with a continuous winner, gnt_ready pulsed for one cycle -> exactly one pop; arb_accept=1 in the cycle after the pop, not in the same cycle; ordering holds.
- Boosted winners accepted with CNT_W=4, 17 boosted accepts -> boost_cnt saturates at 15. Then assert boost_cnt_clr with a boosted accept in the same cycle -> boost_cnt=0.
- Assert rst with 2 entries buffered -> the next cycle shows gnt_v=0, all index_f slices = 7, boost_cnt=0, and no stale grant appears after release.
